seq_divider: RTL

- Parametrised multi-cycle restoring divider for the multi-cycle CPU datapath.
- Successor to the fixed 16-bit divider. Adds:
  - configurable width;
  - a start/busy/done handshake;
  - remainder output;
  - divide-by-zero and overflow flags;
  - optional signed mode.
- Sits beside the ALU. The control unit stalls on busy and captures results on done.

---
 rtl/seq_divider_if.sv | 33 +++
 rtl/seq_divider.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider; carries is_signed only when DIV_SIGNED_EN is defined.
interface seq_divider_if #(
    parameter int W = 16
) ();
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic         is_signed;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    modport master (
`ifdef DIV_SIGNED_EN
        output is_signed,
`endif
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
`ifdef DIV_SIGNED_EN
        input  is_signed,
`endif
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
// Define DIV_SIGNED_EN to add the is_signed input and two's-complement mode with overflow detection.
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave io_bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [W:0]    r_p;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_dvs;
    logic          r_dz_pend;
    logic          r_done;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rem;
    logic          r_dz;

    logic          w_accept;
    logic          w_last;
    logic [W:0]    w_p_sh;
    logic          w_ge;
    logic [W:0]    w_p_nx;
    logic [W-1:0]  w_q_nx;
    logic [W-1:0]  w_quo_fix;
    logic [W-1:0]  w_rem_fix;
    logic [W-1:0]  w_a_mag;
    logic [W-1:0]  w_b_mag;
    logic          w_b_zero;

`ifdef DIV_SIGNED_EN
    logic          r_ov_pend;
    logic          r_ov;
    logic          r_q_neg;
    logic          r_r_neg;
    logic          w_a_neg;
    logic          w_b_neg;
    logic          w_ov_in;
`endif

    assign w_accept = (r_state == S_IDLE) && io_bus.start;
    assign w_last   = (r_state == S_BUSY) && (r_dz_pend || (r_cnt == CW'(1)));
    assign w_b_zero = (io_bus.divisor == '0);

    // Capture-time magnitudes; the sign bookkeeping exists only in the signed build.
`ifdef DIV_SIGNED_EN
    assign w_a_neg = io_bus.is_signed & io_bus.dividend[W-1];
    assign w_b_neg = io_bus.is_signed & io_bus.divisor[W-1];
    assign w_a_mag = w_a_neg ? -io_bus.dividend : io_bus.dividend;
    assign w_b_mag = w_b_neg ? -io_bus.divisor  : io_bus.divisor;
    assign w_ov_in = io_bus.is_signed
                   && (io_bus.dividend == {1'b1, {(W-1){1'b0}}})
                   && (io_bus.divisor == '1);
`else
    assign w_a_mag = io_bus.dividend;
    assign w_b_mag = io_bus.divisor;
`endif

    // r_q doubles as the dividend shift-out and the quotient shift-in register.
    assign w_p_sh = {r_p[W-1:0], r_q[W-1]};
    assign w_ge   = (w_p_sh >= {1'b0, r_dvs});
    assign w_p_nx = w_ge ? (w_p_sh - {1'b0, r_dvs}) : w_p_sh;
    assign w_q_nx = {r_q[W-2:0], w_ge};

`ifdef DIV_SIGNED_EN
    assign w_quo_fix = r_q_neg ? -w_q_nx : w_q_nx;
    assign w_rem_fix = r_r_neg ? -w_p_nx[W-1:0] : w_p_nx[W-1:0];
`else
    assign w_quo_fix = w_q_nx;
    assign w_rem_fix = w_p_nx[W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // NOTE: the default assignment ahead of the case keeps every path driven, so no latch is inferred.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nx = S_BUSY;
            S_BUSY:  if (w_last)   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_dvs     <= '0;
            r_dz_pend <= 1'b0;
            r_done    <= 1'b0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dz      <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_ov_pend <= 1'b0;
            r_ov      <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                // A zero divisor keeps the raw dividend so it can be returned untouched.
                r_q       <= w_b_zero ? io_bus.dividend : w_a_mag;
                r_dvs     <= w_b_mag;
                r_p       <= '0;
                r_cnt     <= CW'(W);
                r_dz_pend <= w_b_zero;
`ifdef DIV_SIGNED_EN
                r_ov_pend <= w_ov_in;
                r_q_neg   <= w_a_neg ^ w_b_neg;
                r_r_neg   <= w_a_neg;
`endif
            end else if (r_state == S_BUSY) begin
                if (w_last) begin
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                    r_dz   <= r_dz_pend;
                    if (r_dz_pend) begin
                        r_quo <= '1;
                        r_rem <= r_q;
                    end else begin
                        r_p   <= w_p_nx;
                        r_q   <= w_q_nx;
                        r_quo <= w_quo_fix;
                        r_rem <= w_rem_fix;
                    end
`ifdef DIV_SIGNED_EN
                    r_ov <= r_ov_pend;
`endif
                end else begin
                    r_p   <= w_p_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end

    assign io_bus.busy        = (r_state == S_BUSY);
    assign io_bus.done        = r_done;
    assign io_bus.quotient    = r_quo;
    assign io_bus.remainder   = r_rem;
    assign io_bus.div_by_zero = r_dz;
`ifdef DIV_SIGNED_EN
    assign io_bus.overflow    = r_ov;
`else
    assign io_bus.overflow    = 1'b0;
`endif
endmodule
